// File: rtl/ext_mem_arb_pkg.sv
// ext_mem_arb_pkg: arbiter state/owner types and the error read-data pattern
package ext_mem_arb_pkg;
  typedef enum logic [2:0] {IDLE, BUSY_H, BUSY_C, RESP_H, RESP_C} state_t;
  typedef enum logic {HOST, CORE} owner_t;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant (in: host_req, core_req, last_owner; out: gnt_h, gnt_c), combinational
module rr_arb2 import ext_mem_arb_pkg::*; (
  input  logic   host_req,
  input  logic   core_req,
  input  owner_t last_owner,
  output logic   gnt_h,
  output logic   gnt_c
);
  assign gnt_h = host_req & (!core_req | last_owner == CORE);
  assign gnt_c = core_req & (!host_req | last_owner == HOST);
endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares one memory port (mem_*) between wishbone host (wbs_*) and core (ext_*), round-robin, one outstanding; ARB_TIMEOUT_EN adds timeout with arb_err
module ext_mem_arbiter import ext_mem_arb_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h3000_0000,
  parameter logic [ADDR_W-1:0] MEM_MASK = 32'hFF00_0000,
  parameter int                TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  input  logic                ext_valid,
  input  logic [ADDR_W-1:0]   ext_address,
  input  logic [DATA_W-1:0]   ext_write_data,
  input  logic [DATA_W/8-1:0] ext_write_strobe,
  output logic                ext_ready,
  output logic [DATA_W-1:0]   ext_read_data,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_err
);
  state_t state, state_n;
  owner_t last_owner;
  logic [DATA_W-1:0] rdata_q;
  logic host_req, host_hit, gnt_h, gnt_c, timeout;
  assign host_req = wbs_cyc_i & wbs_stb_i;
  assign host_hit = (wbs_adr_i & MEM_MASK) == MEM_BASE;
  rr_arb2 u_arb (
    .host_req   (host_req),
    .core_req   (ext_valid),
    .last_owner (last_owner),
    .gnt_h      (gnt_h),
    .gnt_c      (gnt_c)
  );
  assign mem_valid     = state == BUSY_H || state == BUSY_C;
  assign wbs_ack_o     = state == RESP_H;
  assign ext_ready     = state == RESP_C;
  assign wbs_dat_o     = wbs_ack_o ? rdata_q : '0;
  assign ext_read_data = ext_ready ? rdata_q : '0;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= state == IDLE ? '0 : cnt + 8'd1;
      err_q <= timeout;
    end
  // cnt is 0 in the first BUSY cycle, so cnt==TIMEOUT-1 marks the TIMEOUT-th BUSY cycle
  assign timeout = mem_valid && !mem_ready && cnt == 8'(TIMEOUT - 1);
  assign arb_err = err_q;
`else
  assign timeout = 1'b0;
  assign arb_err = 1'b0;
`endif
  // a host miss answers directly from IDLE without touching memory
  always_comb
    state_n = state == IDLE ? (gnt_h ? (host_hit ? BUSY_H : RESP_H) : gnt_c ? BUSY_C : IDLE)
            : mem_valid     ? ((mem_ready || timeout) ? (state == BUSY_H ? RESP_H : RESP_C) : state)
            : IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= CORE;
    end else begin
      state <= state_n;
      if (state == RESP_H) last_owner <= HOST;
      else if (state == RESP_C) last_owner <= CORE;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_we    <= 1'b0;
      rdata_q   <= '0;
    end else if (state == IDLE) begin
      if (gnt_h) begin
        mem_addr  <= wbs_adr_i & ~MEM_MASK;
        mem_wdata <= wbs_dat_i;
        mem_wstrb <= wbs_we_i ? wbs_sel_i : '0;
        mem_we    <= wbs_we_i;
      end else if (gnt_c) begin
        mem_addr  <= ext_address;
        mem_wdata <= ext_write_data;
        mem_wstrb <= ext_write_strobe;
        mem_we    <= |ext_write_strobe;
      end
      rdata_q <= '0;
    end else if (mem_valid && mem_ready) rdata_q <= mem_rdata;
    else if (timeout) rdata_q <= DATA_W'(ERR_RDATA);
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed self-checking bench for ext_mem_arbiter
module tb_ext_mem_arbiter;
  logic clk = 0, reset_n = 0;
  logic wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [3:0] wbs_sel_i = 0;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic ext_valid = 0;
  logic [31:0] ext_address = 0, ext_write_data = 0;
  logic [3:0] ext_write_strobe = 0;
  logic ext_ready;
  logic [31:0] ext_read_data;
  logic mem_valid, mem_we, mem_ready, arb_err;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  int checks = 0, errors = 0;
  int waits = 0;
  logic mem_en = 1;
  logic [7:0] wcnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) wcnt <= mem_valid ? wcnt + 8'd1 : 8'd0;
  assign mem_ready = mem_valid & mem_en & (int'(wcnt) == waits);
  ext_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ext_valid(ext_valid), .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_write_strobe(ext_write_strobe), .ext_ready(ext_ready), .ext_read_data(ext_read_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );
  task test_reset;
    reset_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_valid, wbs_ack_o, ext_ready, arb_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {mem_valid, wbs_ack_o, ext_ready, arb_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, mem_we, wbs_dat_o, ext_read_data} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %b exp all 0", mem_addr, mem_wdata, mem_wstrb, mem_we);
    end
    reset_n = 1;
    @(negedge clk);
  endtask
  task test_host_write;
    int n;
    waits = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0010; wbs_dat_i = 32'hA5A5_5A5A;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        checks++;
        if ({mem_valid, mem_we, mem_wstrb} !== 6'b11_1111) begin
          errors++; $display("FAIL hw_ctrl got v%b we%b s%h exp v1 we1 sF", mem_valid, mem_we, mem_wstrb);
        end
        checks++;
        if (mem_addr !== 32'h10) begin errors++; $display("FAIL hw_addr got %h exp 00000010", mem_addr); end
        checks++;
        if (mem_wdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL hw_wdata got %h exp a5a55a5a", mem_wdata); end
      end
    end while (!wbs_ack_o && n < 20);
    checks++;
    if (n != 2 || !wbs_ack_o) begin errors++; $display("FAIL hw_latency got %0d exp 2", n); end
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL hw_err got %b exp 0", arb_err); end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    @(negedge clk);
    checks++;
    if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL hw_ack_pulse got %b exp 0", wbs_ack_o); end
  endtask
  task test_core_read;
    int n;
    waits = 4; mem_rdata = 32'h1234_5678;
    ext_valid = 1; ext_address = 32'h0000_0040; ext_write_strobe = 0; ext_write_data = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        checks++;
        if ({mem_valid, mem_we, mem_addr} !== {2'b10, 32'h40}) begin
          errors++; $display("FAIL cr_req got v%b we%b a%h exp v1 we0 a00000040", mem_valid, mem_we, mem_addr);
        end
      end
    end while (!ext_ready && n < 20);
    checks++;
    if (n != 6 || !ext_ready) begin errors++; $display("FAIL cr_latency got %0d exp 6", n); end
    checks++;
    if (ext_read_data !== 32'h1234_5678) begin errors++; $display("FAIL cr_rdata got %h exp 12345678", ext_read_data); end
    ext_valid = 0;
    @(negedge clk);
    checks++;
    if (ext_ready !== 1'b0) begin errors++; $display("FAIL cr_ready_pulse got %b exp 0", ext_ready); end
  endtask
  task test_host_miss;
    int n;
    logic seen;
    waits = 0; mem_rdata = 32'hFFFF_FFFF; seen = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h2000_0000;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (mem_valid) seen = 1;
    end while (!wbs_ack_o && n < 20);
    checks++;
    if (n != 1 || !wbs_ack_o) begin errors++; $display("FAIL miss_latency got %0d exp 1", n); end
    checks++;
    if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h exp 00000000", wbs_dat_o); end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (3) begin @(negedge clk); if (mem_valid) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL miss_mem_valid got %b exp 0", seen); end
  endtask
  task test_round_robin;
    int own[4];
    int k;
    logic both;
    test_reset;
    waits = 0; mem_rdata = 32'h55; both = 0; k = 0;
    for (int i = 0; i < 4; i++) own[i] = -1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0020;
    ext_valid = 1; ext_address = 32'h80; ext_write_strobe = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (wbs_ack_o && ext_ready) both = 1;
      if (wbs_ack_o) begin own[k] = 0; k++; end
      else if (ext_ready) begin own[k] = 1; k++; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; ext_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (own[i] != i % 2) begin errors++; $display("FAIL rr_owner%0d got %0d exp %0d", i, own[i], i % 2); end
    end
    checks++;
    if (both) begin errors++; $display("FAIL rr_overlap got 1 exp 0"); end
    repeat (4) @(negedge clk);
  endtask
`ifdef ARB_TIMEOUT_EN
  task test_timeout;
    int n;
    mem_en = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0000;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 300);
    checks++;
    if (n != 256 || !wbs_ack_o) begin errors++; $display("FAIL to_latency got %0d exp 256", n); end
    checks++;
    if (wbs_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got %h exp deadbeef", wbs_dat_o); end
    checks++;
    if (arb_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", arb_err); end
    wbs_cyc_i = 0; wbs_stb_i = 0; mem_en = 1;
    @(negedge clk);
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b exp 0", arb_err); end
    repeat (2) @(negedge clk);
  endtask
`endif
  task test_reset_mid_busy;
    logic rdy;
    int n;
    // a host-owned transaction first so the core would win the next tie without reset
    waits = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0004;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 20);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (2) @(negedge clk);
    mem_en = 0; rdy = 0;
    ext_valid = 1; ext_address = 32'h100; ext_write_strobe = 4'h3;
    repeat (3) begin @(negedge clk); if (ext_ready) rdy = 1; end
    checks++;
    if ({mem_valid, mem_we} !== 2'b11) begin errors++; $display("FAIL rb_busy got v%b we%b exp v1 we1", mem_valid, mem_we); end
    #2 reset_n = 0;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL rb_async got %b exp 0", mem_valid); end
    repeat (3) begin @(negedge clk); if (ext_ready) rdy = 1; end
    checks++;
    if (rdy) begin errors++; $display("FAIL rb_no_ready got 1 exp 0"); end
    mem_en = 1; waits = 0; ext_write_strobe = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0008;
    reset_n = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && !ext_ready && n < 20);
    checks++;
    if ({wbs_ack_o, ext_ready} !== 2'b10) begin
      errors++; $display("FAIL rb_first_grant got ack%b rdy%b exp ack1 rdy0", wbs_ack_o, ext_ready);
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; ext_valid = 0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_host_write;
    test_core_read;
    test_host_miss;
    test_round_robin;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
